// File: rtl/nx_fifo_drain_arb.sv
// Burst-limited round-robin drain of N_REQ show-ahead FIFOs into one registered
// valid/ready stream. Pops the granted FIFO and captures its head in the same cycle.
module nx_fifo_drain_arb #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       q_empty,
  input  logic [N_REQ*WIDTH-1:0] q_rdata,
  input  logic [N_REQ-1:0]       q_en,
  output logic [N_REQ-1:0]       q_ren,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic                   out_first,
  output logic                   dbg_state
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t           r_state;
  logic [SRC_W-1:0] r_owner;
  logic [SRC_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SRC_W-1:0] r_out_src;
  logic             r_out_first;

  logic [N_REQ-1:0] w_elig;
  logic             w_load;
  logic             w_continue;
  logic             w_rot_found;
  logic [SRC_W-1:0] w_rot_idx;
  logic [SRC_W-1:0] w_next_ptr;
  logic             w_grant;
  logic [SRC_W-1:0] w_gidx;
  logic [WIDTH-1:0] w_gdata;

  // Index base+off wrapped modulo N_REQ; off is always below N_REQ.
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return SRC_W'(sum);
  endfunction

  // Output handshake: a beat transfers on any edge where out_valid && out_ready;
  // out_valid never drops without a transfer, and out_data/out_src hold while stalled.
  assign w_elig = q_en & ~q_empty;
  assign w_load = ~r_out_valid | out_ready;

  assign w_continue = (r_state == ST_BURST) && w_elig[r_owner] &&
                      (r_cnt < CNT_W'(MAX_BURST));

  // Scan downward so the smallest offset from r_ptr is the last writer and wins.
  always_comb begin
    w_rot_found = 1'b0;
    w_rot_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_elig[wrap_add(r_ptr, k)]) begin
        w_rot_found = 1'b1;
        w_rot_idx   = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_next_ptr = wrap_add(w_rot_idx, (N_REQ > 1) ? 1 : 0);
  assign w_grant    = w_load && (w_continue || w_rot_found);
  assign w_gidx     = w_continue ? r_owner : w_rot_idx;
  assign w_gdata    = q_rdata[int'(w_gidx) * WIDTH +: WIDTH];

  always_comb begin
    q_ren = '0;
    if (!rst && w_grant) q_ren[w_gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_first <= 1'b0;
    end else if (w_load) begin
      if (w_continue) begin
        r_cnt       <= r_cnt + CNT_W'(1);
        r_out_valid <= 1'b1;
        r_out_data  <= w_gdata;
        r_out_src   <= r_owner;
        r_out_first <= 1'b0;
      end else if (w_rot_found) begin
        r_state     <= ST_BURST;
        r_owner     <= w_rot_idx;
        r_ptr       <= w_next_ptr;
        r_cnt       <= CNT_W'(1);
        r_out_valid <= 1'b1;
        r_out_data  <= w_gdata;
        r_out_src   <= w_rot_idx;
        r_out_first <= 1'b1;
      end else begin
        // Nothing eligible: drop to idle, keep last data/source visible.
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_out_first <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_first = r_out_first;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nx_fifo_drain_arb.sv
// Bench for nx_fifo_drain_arb: behavioural FIFO models, a reference arbiter that
// predicts q_ren and the output beats, table-driven scenarios and corner sequences.
module tb_nx_fifo_drain_arb;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int SW = 2;
  localparam int EW = W + SW + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   q_empty = '1;
  logic [N*W-1:0] q_rdata = '0;
  logic [N-1:0]   q_en = '0;
  logic [N-1:0]   q_ren;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_first;
  logic           dbg_state;

  always #5 clk = ~clk;

  nx_fifo_drain_arb #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_rdata(q_rdata), .q_en(q_en),
    .q_ren(q_ren), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_first(out_first), .dbg_state(dbg_state)
  );

  // Source FIFO models
  logic [W-1:0] f_mem [N][64];
  int f_rd [N];
  int f_wr [N];

  // Scoreboard and reference arbiter state
  logic [EW-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  logic m_valid = 1'b0;
  logic m_busy  = 1'b0;
  int m_owner = 0, m_cnt = 0, m_ptr = 0;
  bit after_rst = 0;
  logic [N-1:0] ren_or = '0;

  logic         nxt_rst   = 1'b1;
  logic [N-1:0] nxt_en    = '0;
  logic         nxt_ready = 1'b1;

  int cyc = 0;
  int log_src [$];
  int log_first [$];
  int log_cyc [$];

  typedef struct {
    logic [31:0] fill;
    logic [3:0]  en;
    int          beats;
    logic [47:0] seq;
    logic [11:0] firsts;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic load_fifos(input logic [31:0] fill);
    for (int i = 0; i < N; i++) begin
      f_rd[i] = 0;
      f_wr[i] = 0;
      for (int k = 0; k < int'(fill[8*i +: 8]); k++) begin
        f_mem[i][f_wr[i]] = W'($urandom_range(1, 255));
        f_wr[i]++;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0]  elig;
    logic [N-1:0]  exp_ren;
    logic [EW-1:0] e;
    int g;
    logic first_b;
    @(negedge clk);
    rst = nxt_rst;
    q_en = nxt_en;
    out_ready = nxt_ready;
    for (int i = 0; i < N; i++) begin
      q_empty[i] = (f_rd[i] == f_wr[i]);
      q_rdata[i*W +: W] = q_empty[i] ? '0 : f_mem[i][f_rd[i]];
    end
    #1;
    cyc++;
    ren_or = ren_or | q_ren;
    chk("out_valid", out_valid, m_valid);
    if (after_rst) begin
      chk("rst_data", out_data, 0);
      chk("rst_src", out_src, 0);
      chk("rst_first", out_first, 0);
      chk("rst_state", dbg_state, 0);
      after_rst = 0;
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat_unexpected: got src %0d data %0h, expected no beat", out_src, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {out_first, out_src, out_data}, e);
      end
      log_src.push_back(int'(out_src));
      log_first.push_back(int'(out_first));
      log_cyc.push_back(cyc);
    end
    if (rst) begin
      chk("ren_in_rst", q_ren, 0);
      m_valid = 1'b0; m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      exp_q.delete();
      after_rst = 1;
    end else begin
      elig = q_en & ~q_empty;
      exp_ren = '0;
      g = -1;
      first_b = 1'b0;
      if (!m_valid || out_ready) begin
        if (m_busy && elig[m_owner] && m_cnt < MB) begin
          g = m_owner;
          m_cnt++;
        end else begin
          for (int k = 0; k < N; k++)
            if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          if (g >= 0) begin
            first_b = 1'b1; m_owner = g; m_cnt = 1; m_ptr = (g + 1) % N; m_busy = 1'b1;
          end else m_busy = 1'b0;
        end
        if (g >= 0) begin
          exp_ren[g] = 1'b1;
          exp_q.push_back({first_b, SW'(g), f_mem[g][f_rd[g]]});
          f_rd[g]++;
          m_valid = 1'b1;
        end else m_valid = 1'b0;
      end
      chk("q_ren", q_ren, exp_ren);
    end
    @(posedge clk);
  endtask

  task automatic start_run(input logic [31:0] fill, input logic [3:0] en);
    nxt_rst = 1'b1; nxt_en = en; nxt_ready = 1'b1;
    load_fifos(fill);
    repeat (3) tick();
    nxt_rst = 1'b0;
    log_src.delete(); log_first.delete(); log_cyc.delete();
    ren_or = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    start_run(v.fill, v.en);
    repeat (v.beats + 6) tick();
    chk("vec_beats", log_src.size(), v.beats);
    chk("vec_drained", exp_q.size(), 0);
    n = (v.beats < 12) ? v.beats : 12;
    for (int k = 0; k < n && k < log_src.size(); k++) begin
      chk("vec_src", log_src[k], v.seq[4*k +: 4]);
      chk("vec_first", log_first[k], v.firsts[k]);
    end
    if (log_cyc.size() > 0)
      chk("vec_no_bubble", log_cyc[log_cyc.size()-1] - log_cyc[0] + 1, v.beats);
  endtask

  initial begin
    logic [W-1:0]  hd;
    logic [SW-1:0] hs;
    int bp_src [8];
    vecs[0] = '{fill:32'h08080808, en:4'hF, beats:32, seq:48'h222211110000, firsts:12'h111};
    vecs[1] = '{fill:32'h08080208, en:4'hF, beats:26, seq:48'h332222110000, firsts:12'h451};
    vecs[2] = '{fill:32'h08080808, en:4'hA, beats:16, seq:48'h111133331111, firsts:12'h111};
    vecs[3] = '{fill:32'h00030001, en:4'hF, beats:4,  seq:48'h000000002220, firsts:12'h003};
    vecs[4] = '{fill:32'h06000502, en:4'hF, beats:13, seq:48'h313333111100, firsts:12'hC45};
    bp_src = '{0, 0, 0, 0, 1, 1, 1, 1};

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Backpressure mid-burst: output must freeze and the burst resume where it stopped.
    start_run(32'h08080808, 4'hF);
    tick(); tick();
    nxt_ready = 1'b0;
    tick();
    #1;
    hd = out_data;
    hs = out_src;
    chk("bp_owner", hs, 0);
    repeat (4) begin
      tick();
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data_hold", out_data, hd);
      chk("bp_src_hold", out_src, hs);
    end
    nxt_ready = 1'b1;
    repeat (12) tick();
    for (int k = 0; k < 8 && k < log_src.size(); k++) begin
      chk("bp_seq", log_src[k], bp_src[k]);
      chk("bp_first", log_first[k], (k == 0 || k == 4) ? 1 : 0);
    end

    // Mask: only 1 and 3 served; dropping q_en[1] mid-burst rotates to 3.
    start_run(32'h08080808, 4'hA);
    tick(); tick();
    nxt_en = 4'h8;
    repeat (10) tick();
    chk("mask_ren02", {ren_or[2], ren_or[0]}, 0);
    if (log_src.size() >= 4) begin
      chk("mask_b0", log_src[0], 1);
      chk("mask_b1", log_src[1], 1);
      chk("mask_b2", log_src[2], 3);
      chk("mask_b2_first", log_first[2], 1);
      chk("mask_b3", log_src[3], 3);
    end else chk("mask_beats", log_src.size(), 4);

    // Reset while src 2 holds a pending beat.
    start_run(32'h08080808, 4'hF);
    repeat (10) tick();
    #1;
    chk("mr_owner", out_src, 2);
    chk("mr_valid", out_valid, 1);
    nxt_rst = 1'b1;
    tick();
    nxt_rst = 1'b0;
    log_src.delete(); log_first.delete(); log_cyc.delete();
    repeat (4) tick();
    if (log_src.size() > 0) begin
      chk("mr_regrant_src", log_src[0], 0);
      chk("mr_regrant_first", log_first[0], 1);
    end else chk("mr_regrant_beats", log_src.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
